// File: rtl/factor_scan_unit.sv
// -----------------------------------------------------------------------------
// factor_scan_unit
//
// Tests a latched operand for divisibility by every divisor from 2 to 15.
// It uses one bit-serial restoring division per divisor, consuming one
// operand bit per clock, MSB first. A full scan therefore takes 14*WIDTH
// cycles. The result vector is published together with a one-cycle done
// pulse.
//
// Ports
//   clk           : single clock; all state changes on its rising edge
//   rst_n         : asynchronous, active-low reset
//   number        : operand, sampled only on the edge where start is accepted
//   start         : request; honoured only while idle, ignored during a scan
//   busy          : high while a scan is running
//   done          : one-cycle pulse in the first idle cycle after a scan
//   factors       : bit k set iff (k+2) divides the latched operand
//   factors_valid : high while factors holds the most recent complete result
// -----------------------------------------------------------------------------
module factor_scan_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] number,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [13:0]      factors,
    output logic             factors_valid
);

    localparam int NUM_DIV   = 14;
    localparam int BIT_IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [BIT_IDX_W-1:0] BIT_IDX_MSB = BIT_IDX_W'(WIDTH - 1);
    localparam logic [3:0]           DIV_FIRST   = 4'd2;
    localparam logic [3:0]           DIV_LAST    = 4'd15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Datapath registers
    logic [WIDTH-1:0]     number_reg;
    logic [WIDTH-1:0]     number_next;
    logic [3:0]           divisor_reg;
    logic [3:0]           divisor_next;
    logic [BIT_IDX_W-1:0] bit_idx_reg;
    logic [BIT_IDX_W-1:0] bit_idx_next;
    // Remainder is always < divisor <= 15, so after the shift it is at most
    // 31 and fits 5 bits without overflow.
    logic [4:0]           rem_reg;
    logic [4:0]           rem_next;

    // Output registers
    logic                 busy_reg;
    logic                 busy_next;
    logic                 done_reg;
    logic                 done_next;
    logic                 factors_valid_reg;
    logic                 factors_valid_next;
    logic [NUM_DIV-1:0]   factors_reg;
    logic [NUM_DIV-1:0]   factors_next;

    // Step qualifiers
    logic                 start_accept;
    logic                 last_bit;
    logic                 divisor_done;
    logic                 scan_end;

    // One restoring-division step
    logic                 cur_bit;
    logic [4:0]           rem_shift;
    logic [4:0]           rem_step;
    logic                 rem_is_zero;

    assign start_accept = (state_reg == ST_IDLE) && start;
    assign last_bit     = (bit_idx_reg == '0);
    assign divisor_done = (state_reg == ST_RUN) && last_bit;
    assign scan_end     = divisor_done && (divisor_reg == DIV_LAST);

    assign cur_bit     = number_reg[bit_idx_reg];
    assign rem_shift   = {rem_reg[3:0], cur_bit};
    assign rem_step    = (rem_shift >= {1'b0, divisor_reg})
                         ? (rem_shift - {1'b0, divisor_reg})
                         : rem_shift;
    assign rem_is_zero = (rem_step == 5'd0);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: if (start)    state_next = ST_RUN;
            ST_RUN:  if (scan_end) state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output / datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        number_next        = number_reg;
        divisor_next       = divisor_reg;
        bit_idx_next       = bit_idx_reg;
        rem_next           = rem_reg;
        factors_valid_next = factors_valid_reg;
        busy_next          = (state_next == ST_RUN);
        done_next          = scan_end;

        unique case (state_reg)
            ST_IDLE: begin
                if (start_accept) begin
                    number_next        = number;
                    divisor_next       = DIV_FIRST;
                    bit_idx_next       = BIT_IDX_MSB;
                    rem_next           = 5'd0;
                    factors_valid_next = 1'b0;
                end
            end
            ST_RUN: begin
                if (last_bit) begin
                    // Divisor finished: restart the division for the next
                    // divisor. Wrap-around of divisor after 15 is harmless
                    // since the scan ends on that same edge.
                    rem_next     = 5'd0;
                    bit_idx_next = BIT_IDX_MSB;
                    divisor_next = divisor_reg + 4'd1;
                end else begin
                    rem_next     = rem_step;
                    bit_idx_next = bit_idx_reg - BIT_IDX_W'(1);
                end
                if (scan_end) begin
                    factors_valid_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Each result bit is written only on the final bit of its own divisor.
    // Bits for divisors not yet reached keep the previous scan's value.
    generate
        for (genvar gi = 0; gi < NUM_DIV; gi++) begin : g_factor
            logic wr_en;
            assign wr_en            = divisor_done && (divisor_reg == 4'(gi + 2));
            assign factors_next[gi] = wr_en ? rem_is_zero : factors_reg[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Datapath and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            number_reg        <= '0;
            divisor_reg       <= 4'd0;
            bit_idx_reg       <= '0;
            rem_reg           <= 5'd0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
            factors_valid_reg <= 1'b0;
            factors_reg       <= '0;
        end else begin
            number_reg        <= number_next;
            divisor_reg       <= divisor_next;
            bit_idx_reg       <= bit_idx_next;
            rem_reg           <= rem_next;
            busy_reg          <= busy_next;
            done_reg          <= done_next;
            factors_valid_reg <= factors_valid_next;
            factors_reg       <= factors_next;
        end
    end

    assign busy          = busy_reg;
    assign done          = done_reg;
    assign factors       = factors_reg;
    assign factors_valid = factors_valid_reg;

endmodule

// File: tb/tb_factor_scan_unit.sv
// -----------------------------------------------------------------------------
// tb_factor_scan_unit
//
// Directed and random scans of factor_scan_unit (WIDTH=8). Expected results
// come from a plain modulo divisibility model. Inputs are driven and outputs
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_factor_scan_unit;

    localparam int WIDTH   = 8;
    localparam int LATENCY = 14 * WIDTH;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] number;
    logic             start;
    logic             busy;
    logic             done;
    logic [13:0]      factors;
    logic             factors_valid;

    int          n_checks;
    int          n_fail;
    logic [13:0] last_factors;

    factor_scan_unit #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .number        (number),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .factors       (factors),
        .factors_valid (factors_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: bit (d-2) set iff d divides n, for d = 2..15.
    function automatic logic [13:0] ref_factors(input int n);
        logic [13:0] r;
        r = '0;
        for (int d = 2; d <= 15; d++) begin
            r[d-2] = ((n % d) == 0);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete scan starting at the next rising edge. During the scan
    // number is either scrambled (noise) or, from cycle 'disturb' on, forced
    // to dn with a one-cycle start pulse at that cycle.
    task automatic run_scan(input logic [WIDTH-1:0] n, input int disturb,
                            input logic [WIDTH-1:0] dn, input bit noise);
        logic [13:0] exp;
        int          cycles;
        int          busy_cnt;
        bit          seen;
        exp    = ref_factors(int'(n));
        number = n;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        check("busy_after_start", busy, 1);
        check("fv_cleared", factors_valid, 0);
        check("factors_held", factors, last_factors);
        cycles   = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        while (cycles < 3 * LATENCY) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            if (disturb >= 0) begin
                start = (cycles == disturb);
                if (cycles >= disturb) number = dn;
            end else if (noise) begin
                number = WIDTH'($urandom);
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        check("latency", cycles, LATENCY);
        check("busy_cycles", busy_cnt, LATENCY);
        check("busy_at_done", busy, 0);
        check("factors", factors, exp);
        check("fv_at_done", factors_valid, 1);
        $display("scan number=%0d factors=%04h expected=%04h latency=%0d", n, factors, exp, cycles);
        last_factors = exp;
        @(negedge clk);
        check("done_single", done, 0);
        check("fv_hold", factors_valid, 1);
    endtask

    initial begin
        int n_done;
        int gap;
        n_checks     = 0;
        n_fail       = 0;
        last_factors = '0;
        rst_n        = 1'b0;
        start        = 1'b0;
        number       = '0;

        // Reset state
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_factors", factors, 0);
        check("rst_fv", factors_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operands, including boundaries
        run_scan(8'd12,  -1, 8'd0, 1'b0);
        check("n12_const", factors, 14'h0417);
        run_scan(8'd0,   -1, 8'd0, 1'b1);
        run_scan(8'd1,   -1, 8'd0, 1'b1);
        run_scan(8'd255, -1, 8'd0, 1'b1);
        run_scan(8'd120, -1, 8'd0, 1'b1);

        // Start and operand changes during a scan are ignored
        run_scan(8'd13, 40, 8'd12, 1'b0);
        check("ignored_start_idle", busy, 0);
        check("n13_const", factors, 14'h0800);

        // Asynchronous reset mid-scan
        number = 8'd77;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (50) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_factors", factors, 0);
        check("abort_fv", factors_valid, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        repeat (2 * LATENCY) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        last_factors = '0;
        run_scan(8'd6, -1, 8'd0, 1'b1);

        // Back-to-back: start held high, done every LATENCY+1 cycles
        number = 8'd12;
        start  = 1'b1;
        @(negedge clk);
        n_done = 0;
        for (int c = 0; c <= 3 * (LATENCY + 1) - 1; c++) begin
            check("b2b_done", done, ((c % (LATENCY + 1)) == LATENCY));
            check("b2b_fv", factors_valid, ((c % (LATENCY + 1)) == LATENCY));
            if (done) begin
                n_done++;
                check("b2b_factors", factors, 14'h0417);
                $display("b2b done #%0d at cycle %0d factors=%04h", n_done, c, factors);
            end
            if (c == 3 * (LATENCY + 1) - 1) start = 1'b0;
            @(negedge clk);
        end
        check("b2b_count", n_done, 3);
        check("b2b_idle", busy, 0);
        last_factors = 14'h0417;

        // Exhaustive operands with a scrambled number input during each scan
        for (int n = 0; n < (1 << WIDTH); n++) begin
            run_scan(WIDTH'(n), -1, 8'd0, 1'b1);
        end

        // Random operands with random idle gaps
        for (int i = 0; i < 20; i++) begin
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            run_scan(WIDTH'($urandom), -1, 8'd0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
